alu_self_test: RTL and testbench
================================

ALU_SELF_TEST -- requirements
Module: alu_self_test

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 19, number of table entries exercised (1..19).
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0; when 1, the run ends at the first mismatch.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-006 SHALL have port aluOp  output  4  op-code driven to ALU under test.
REQ-007 SHALL have port din1  output  32  first ALU operand (shift amount for shifts).
REQ-008 SHALL have port din2  output  32  second ALU operand.
REQ-009 SHALL have port dout  input  32  ALU result.
REQ-010 SHALL have port exception  input  1  ALU overflow flag.
REQ-011 SHALL have port busy  output  1  high while a run is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-013 SHALL have port pass  output  1  1 when last run had zero mismatches.
REQ-014 SHALL have port failCount  output  5  mismatch count of last run.
REQ-015 SHALL have port firstFail  output  5  index of first mismatching vector; 31 when none.

Function
REQ-016 SHALL be the driving/checking end of the ALU interface: aluOp/din1/din2 registered, dout/exception sampled.
REQ-017 SHALL use FSM states IDLE, CHECK, DONE; IDLE->CHECK on start, CHECK->DONE after last compare, DONE->IDLE after one cycle.
REQ-018 SHALL, on the edge where start=1 in IDLE, load vector 0 onto aluOp/din1/din2, set index=0, clear failCount, set firstFail=31, pass=0.
REQ-019 SHALL, on each edge in CHECK, compare dout/exception against vector[index] expectations, then load vector[index+1]; one vector per cycle.
REQ-020 SHALL compare only exception when expected exception=1 (dout ignored); otherwise compare both dout and exception.
REQ-021 SHALL, on mismatch, increment failCount (saturating at 31) and set firstFail=index if firstFail==31.
REQ-022 SHALL enter DONE after comparing index NUM_VECTORS-1, or after the first mismatch when STOP_ON_FAIL=1.
REQ-023 SHALL assert done for exactly the DONE cycle, with pass=(failCount==0) valid from that cycle until the next start.
REQ-024 SHALL assert busy in CHECK and DONE; start while busy SHALL be ignored.
REQ-025 SHALL hold aluOp/din1/din2 at their last vector in DONE/IDLE.
REQ-026 SHALL take done at the 19th edge after the start edge for NUM_VECTORS=19, no mismatches.
REQ-027 SHALL use the op-code map 0 add,1 addu,2 sub,3 subu,4 slt,5 sltu,6 and,7 lui,8 nor,9 or,10 xor,11 sllv,12 srav,13 srlv.
REQ-028 SHALL use the 19-entry vector table in this order: add 5+3=8; add 7FFFFFFF+7FFFFFFF exc; addu same =FFFFFFFE; sub 5-3=2; sub 7FFFFFFF-80000000 exc; subu same =FFFFFFFF; slt (7FFFFFFF,80000000)=0; slt (80000000,7FFFFFFF)=1; sltu (FFFFFFFF,0)=0; sltu (0,FFFFFFFF)=1; and 5,3=1; lui din2=ABCD =ABCD0000 (din1=0); nor 5,3=FFFFFFF8; or=7; xor=6; sllv 4,12345678=23456780; srav 4,12345678=01234567; srav 4,87654321=F8765432; srlv 4,87654321=08765432.

Reset
REQ-029 SHALL, when rst=1 at an edge (including mid-run), set state=IDLE, aluOp=0, din1=0, din2=0, busy=0, done=0, pass=0, failCount=0, firstFail=31.
REQ-030 SHALL give rst priority over start on the same edge.

Structure
REQ-031 SHALL place op-code constants, vector record typedef {aluOp,din1,din2,expDout,expExc} and the 19-entry table constant in a shared package alu_pkg.
REQ-032 SHALL be one module with no sub-modules; table read is combinational indexing of the package constant.

Verification
REQ-033 SHALL test: correct ALU attached, start pulse -> done 19 cycles later, pass=1, failCount=0, firstFail=31.
REQ-034 SHALL test: ALU with dout bit0 inverted for aluOp=6 -> pass=0, failCount=1, firstFail=10.
REQ-035 SHALL test: exception stuck at 0 -> failCount=2, firstFail=1 (vectors 1 and 4).
REQ-036 SHALL test: STOP_ON_FAIL=1, exception stuck at 0 -> done 2 cycles after start, failCount=1, firstFail=1.
REQ-037 SHALL test: rst asserted at vector 7 -> next cycle busy=0, failCount=0, firstFail=31; later start reruns fully.
REQ-038 SHALL test: start re-pulsed at vector 5 -> ignored; done still 19 cycles after original start.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op-codes, test-vector record and the fixed self-test vector table.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_LUI  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_SLLV = 4'd11;
    localparam logic [3:0] OP_SRAV = 4'd12;
    localparam logic [3:0] OP_SRLV = 4'd13;
    localparam int NUM_TABLE = 19;
    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] din1;
        logic [31:0] din2;
        logic [31:0] exp_dout;
        logic        exp_exc;
    } vec_t;
    // exp_dout is a don't-care on overflow entries
    localparam vec_t VECTORS [NUM_TABLE] = '{
        '{OP_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0},
        '{OP_ADD,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1},
        '{OP_ADDU, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0},
        '{OP_SUB,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0},
        '{OP_SUB,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1},
        '{OP_SUBU, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0},
        '{OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0},
        '{OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0},
        '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0},
        '{OP_SLTU, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
        '{OP_AND,  32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1'b0},
        '{OP_LUI,  32'h0000_0000, 32'h0000_ABCD, 32'hABCD_0000, 1'b0},
        '{OP_NOR,  32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFF8, 1'b0},
        '{OP_OR,   32'h0000_0005, 32'h0000_0003, 32'h0000_0007, 1'b0},
        '{OP_XOR,  32'h0000_0005, 32'h0000_0003, 32'h0000_0006, 1'b0},
        '{OP_SLLV, 32'h0000_0004, 32'h1234_5678, 32'h2345_6780, 1'b0},
        '{OP_SRAV, 32'h0000_0004, 32'h1234_5678, 32'h0123_4567, 1'b0},
        '{OP_SRAV, 32'h0000_0004, 32'h8765_4321, 32'hF876_5432, 1'b0},
        '{OP_SRLV, 32'h0000_0004, 32'h8765_4321, 32'h0876_5432, 1'b0}
    };
endpackage

// File: rtl/alu_self_test.sv
// alu_self_test: drives the vector table into an attached ALU, one vector per cycle,
// and reports mismatch count, first failing index and pass/fail at the end of a run.
module alu_self_test
    import alu_pkg::*;
#(
    parameter int NUM_VECTORS  = 19,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  aluOp,
    output logic [31:0] din1,
    output logic [31:0] din2,
    input  logic [31:0] dout,
    input  logic        exception,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  failCount,
    output logic [4:0]  firstFail
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic [4:0] idx, idx_nx, fail_nx;
    vec_t cur, nxt;
    logic mismatch, stop;
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb begin
        cur = VECTORS[idx];
        idx_nx = (idx == 5'(NUM_TABLE - 1)) ? idx : idx + 5'd1;
        nxt = VECTORS[idx_nx];
        mismatch = cur.exp_exc ? !exception : (exception || dout != cur.exp_dout);
        fail_nx = (mismatch && failCount != 5'd31) ? failCount + 5'd1 : failCount;
        stop = (idx == 5'(NUM_VECTORS - 1)) || (STOP_ON_FAIL && mismatch);
        state_nx = state == IDLE  ? (start ? CHECK : IDLE) :
                   state == CHECK ? (stop ? DONE : CHECK) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            aluOp     <= '0;
            din1      <= '0;
            din2      <= '0;
            idx       <= '0;
            pass      <= 1'b0;
            failCount <= '0;
            firstFail <= 5'd31;
        end else if (state == IDLE && start) begin
            aluOp     <= VECTORS[0].alu_op;
            din1      <= VECTORS[0].din1;
            din2      <= VECTORS[0].din2;
            idx       <= '0;
            pass      <= 1'b0;
            failCount <= '0;
            firstFail <= 5'd31;
        end else if (state == CHECK) begin
            failCount <= fail_nx;
            if (mismatch && firstFail == 5'd31) firstFail <= idx;
            if (stop) pass <= fail_nx == 5'd0;
            else begin
                idx   <= idx_nx;
                aluOp <= nxt.alu_op;
                din1  <= nxt.din1;
                din2  <= nxt.din2;
            end
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_alu_self_test.sv
// tb_alu_self_test: random fault injection into a behavioural ALU; expected results
// come from the bench's own ALU arithmetic and an independent stimulus list.
module tb_alu_self_test;
    logic clk = 1'b0, rst = 1'b1, start_x = 1'b0, sel = 1'b0;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    localparam logic [3:0] S_OP [19] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5,
                                         4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd12, 4'd13};
    localparam logic [31:0] S_A [19] = '{32'h5, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h7FFFFFFF,
                                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0,
                                         32'h5, 32'h0, 32'h5, 32'h5, 32'h5, 32'h4, 32'h4, 32'h4, 32'h4};
    localparam logic [31:0] S_B [19] = '{32'h3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3, 32'h80000000,
                                         32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF,
                                         32'h3, 32'hABCD, 32'h3, 32'h3, 32'h3, 32'h12345678, 32'h12345678,
                                         32'h87654321, 32'h87654321};
    logic [31:0] cdout [20];
    logic        cexc  [20];
    logic [3:0]  op_m, op_s;
    logic [31:0] a_m, b_m, a_s, b_s, dout_m, dout_s;
    logic        exc_m, exc_s, busy_m, busy_s, done_m, done_s, pass_m, pass_s;
    logic [4:0]  fc_m, fc_s, ff_m, ff_s;
    logic [32:0] r_m, r_s;
    int          k_m, k_s;
    wire start_m = start_x & ~sel;
    wire start_s = start_x & sel;
    wire [3:0]  op_x   = sel ? op_s : op_m;
    wire [31:0] a_x    = sel ? a_s : a_m;
    wire [31:0] b_x    = sel ? b_s : b_m;
    wire        busy_x = sel ? busy_s : busy_m;
    wire        done_x = sel ? done_s : done_m;
    wire        pass_x = sel ? pass_s : pass_m;
    wire [4:0]  fc_x   = sel ? fc_s : fc_m;
    wire [4:0]  ff_x   = sel ? ff_s : ff_m;
    alu_self_test dut (
        .clk(clk), .rst(rst), .start(start_m), .aluOp(op_m), .din1(a_m), .din2(b_m),
        .dout(dout_m), .exception(exc_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .failCount(fc_m), .firstFail(ff_m)
    );
    alu_self_test #(.NUM_VECTORS(19), .STOP_ON_FAIL(1'b1)) dut_sf (
        .clk(clk), .rst(rst), .start(start_s), .aluOp(op_s), .din1(a_s), .din2(b_s),
        .dout(dout_s), .exception(exc_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .failCount(fc_s), .firstFail(ff_s)
    );
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s, d, r;
        logic v;
        s = a + b;
        d = a - b;
        v = 1'b0;
        case (op)
            4'd0:    begin r = s; v = (a[31] == b[31]) && (s[31] != a[31]); end
            4'd1:    r = s;
            4'd2:    begin r = d; v = (a[31] != b[31]) && (d[31] != a[31]); end
            4'd3:    r = d;
            4'd4:    r = {31'd0, $signed(a) < $signed(b)};
            4'd5:    r = {31'd0, a < b};
            4'd6:    r = a & b;
            4'd7:    r = {b[15:0], 16'h0};
            4'd8:    r = ~(a | b);
            4'd9:    r = a | b;
            4'd10:   r = a ^ b;
            4'd11:   r = b << a[4:0];
            4'd12:   r = $signed(b) >>> a[4:0];
            4'd13:   r = b >> a[4:0];
            default: r = '0;
        endcase
        return {v, r};
    endfunction
    function automatic int find_idx(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 19; i++)
            if (S_OP[i] == op && S_A[i] == a && S_B[i] == b) return i;
        return 19;
    endfunction
    always_comb begin
        k_m = find_idx(op_m, a_m, b_m);
        r_m = alu_ref(op_m, a_m, b_m);
        dout_m = r_m[31:0] ^ cdout[k_m];
        exc_m = r_m[32] ^ cexc[k_m];
        k_s = find_idx(op_s, a_s, b_s);
        r_s = alu_ref(op_s, a_s, b_s);
        dout_s = r_s[31:0] ^ cdout[k_s];
        exc_s = r_s[32] ^ cexc[k_s];
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic clear_faults();
        for (int i = 0; i < 20; i++) begin
            cdout[i] = '0;
            cexc[i] = 1'b0;
        end
    endtask
    task automatic predict(input bit sf, output int cnt, output int first, output int last);
        logic [32:0] r;
        logic mis;
        cnt = 0;
        first = 31;
        last = 18;
        for (int i = 0; i < 19; i++) begin
            r = alu_ref(S_OP[i], S_A[i], S_B[i]);
            mis = r[32] ? cexc[i] : (cdout[i] != 0 || cexc[i]);
            if (mis) begin
                if (cnt < 31) cnt++;
                if (first == 31) first = i;
                if (sf) begin
                    last = i;
                    break;
                end
            end
        end
    endtask
    task automatic run(input string tag, input int rep_at);
        int cnt, first, last, cyc;
        predict(sel, cnt, first, last);
        @(negedge clk);
        start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        chk({tag, "_busy"}, 32'(busy_x), 32'd1);
        chk({tag, "_op0"}, 32'(op_x), 32'(S_OP[0]));
        chk({tag, "_a0"}, a_x, S_A[0]);
        chk({tag, "_b0"}, b_x, S_B[0]);
        cyc = 0;
        while (!done_x && cyc < 40) begin
            if (cyc == rep_at) start_x = 1'b1;
            @(negedge clk);
            start_x = 1'b0;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(last + 1));
        chk({tag, "_pass"}, 32'(pass_x), 32'(cnt == 0));
        chk({tag, "_fc"}, 32'(fc_x), 32'(cnt));
        chk({tag, "_ff"}, 32'(ff_x), 32'(first));
        chk({tag, "_hold_op"}, 32'(op_x), 32'(S_OP[last]));
        chk({tag, "_hold_b"}, b_x, S_B[last]);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done_x), 32'd0);
        chk({tag, "_idle"}, 32'(busy_x), 32'd0);
        chk({tag, "_pass_kept"}, 32'(pass_x), 32'(cnt == 0));
    endtask
    initial begin
        clear_faults();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        chk("rst_pass", 32'(pass_m), 32'd0);
        chk("rst_fc", 32'(fc_m), 32'd0);
        chk("rst_ff", 32'(ff_m), 32'd31);
        chk("rst_op", 32'(op_m), 32'd0);
        chk("rst_a", a_m, 32'd0);
        chk("rst_b", b_m, 32'd0);
        chk("rst_ff_sf", 32'(ff_s), 32'd31);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start_x = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_x = 1'b0;
        chk("rst_over_start", 32'(busy_m), 32'd0);
        run("clean", -1);
        cdout[10] = 32'h1;
        run("and_bit0", -1);
        clear_faults();
        cexc[1] = 1'b1;
        cexc[4] = 1'b1;
        run("exc_stuck", -1);
        sel = 1'b1;
        run("stop_on_fail", -1);
        sel = 1'b0;
        clear_faults();
        run("restart_ignored", 5);
        cexc[1] = 1'b1;
        cexc[4] = 1'b1;
        @(negedge clk);
        start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_fc", 32'(fc_m), 32'd2);
        chk("mid_op", 32'(op_m), 32'(S_OP[7]));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_m), 32'd0);
        chk("mid_rst_fc", 32'(fc_m), 32'd0);
        chk("mid_rst_ff", 32'(ff_m), 32'd31);
        chk("mid_rst_op", 32'(op_m), 32'd0);
        clear_faults();
        run("rerun", -1);
        for (int n = 0; n < 10; n++) begin
            clear_faults();
            for (int i = 0; i < 19; i++) begin
                case ($urandom_range(0, 5))
                    0: cdout[i] = $urandom | 32'h1;
                    1: cexc[i] = 1'b1;
                    default: ;
                endcase
            end
            sel = 1'($urandom_range(0, 1));
            run("rand", -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
